// File: rtl/ternary_serial_sub.sv
// ternary_serial_sub: digit-serial ternary subtractor, A - B over NTRITS
// unsigned trits, one trit per clock LSB first, with a registered borrow.
// Trit encoding: 2'b00=0, 2'b01=1, 2'b10=2, 2'b11=illegal.
module ternary_serial_sub #(
    parameter int NTRITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2*NTRITS-1:0] a_trits,
    input  logic [2*NTRITS-1:0] b_trits,
    output logic                busy,
    output logic                done,
    output logic [2*NTRITS-1:0] diff,
    output logic [1:0]          borrow_out,
    output logic                err
);

    localparam int W  = 2 * NTRITS;
    localparam int CW = $clog2(NTRITS) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    diff_q, diff_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            borrow_q, borrow_d;
    logic [1:0]      bout_q, bout_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            op_bad;
    logic [1:0]      a_t, b_t;
    logic signed [2:0] t_raw;
    logic [2:0]      t_adj;
    logic            t_brw;
    logic            last_trit;

    // Trit datapath: flag illegal operands, pick the current trit pair and
    // form a[k] - b[k] - borrow, folding negatives back into 0..2.
    always_comb begin
        op_bad = 1'b0;
        for (int i = 0; i < NTRITS; i++) begin
            if (a_trits[2*i +: 2] == 2'b11 || b_trits[2*i +: 2] == 2'b11)
                op_bad = 1'b1;
        end
        a_t = 2'b00;
        b_t = 2'b00;
        for (int i = 0; i < NTRITS; i++) begin
            if (cnt_q == CW'(i)) begin
                a_t = a_q[2*i +: 2];
                b_t = b_q[2*i +: 2];
            end
        end
        t_raw = $signed({1'b0, a_t}) - $signed({1'b0, b_t}) - $signed({2'b00, borrow_q});
        if (t_raw[2]) begin
            t_adj = 3'(t_raw + 3'sd3);
            t_brw = 1'b1;
        end else begin
            t_adj = 3'(t_raw);
            t_brw = 1'b0;
        end
        last_trit = (cnt_q == CW'(NTRITS - 1));
    end

    // Next-state / next-output logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a_trits;
                    b_d      = b_trits;
                    diff_d   = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    bout_d   = 2'b00;
                    if (op_bad) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                for (int i = 0; i < NTRITS; i++) begin
                    if (cnt_q == CW'(i))
                        diff_d[2*i +: 2] = t_adj[1:0];
                end
                borrow_d = t_brw;
                cnt_d    = cnt_q + CW'(1);
                if (last_trit) begin
                    // Final borrow is published on DONE entry so it is
                    // already valid alongside the done pulse.
                    bout_d  = {1'b0, t_brw};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 2'b00;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign err        = err_q;

endmodule
